// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-side branch predictor: 2-bit counter
// encodings, reset/allocation values and saturating helpers.
package bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_e;

   localparam ctr_e CTR_RESET = WNT;
   localparam ctr_e CTR_ALLOC = WT;

   function automatic ctr_e sat2_next(input ctr_e ctr, input logic taken);
      ctr_e nxt;
      nxt = ctr;
      case (ctr)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? WT  : SNT;
         WT:      nxt = taken ? ST  : WNT;
         default: nxt = taken ? ST  : WT;
      endcase
      return nxt;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: combinational fetch-side read, combinational
// resolve-side read for read-modify-write, one synchronous write port.
module btb_table
   import bp_pkg::*;
#(
   parameter int IDX_BITS = 6,
   parameter int TAG_BITS = 30 - IDX_BITS
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IDX_BITS-1:0] rd_idx_i,
   output logic                rd_valid_o,
   output logic [TAG_BITS-1:0] rd_tag_o,
   output logic [31:0]         rd_target_o,
   output ctr_e                rd_ctr_o,
   input  logic [IDX_BITS-1:0] upd_idx_i,
   output logic                upd_valid_o,
   output logic [TAG_BITS-1:0] upd_tag_o,
   output logic [31:0]         upd_target_o,
   output ctr_e                upd_ctr_o,
   input  logic                we_i,
   input  logic                wr_valid_i,
   input  logic [TAG_BITS-1:0] wr_tag_i,
   input  logic [31:0]         wr_target_i,
   input  ctr_e                wr_ctr_i
);

   localparam int ENTRIES = 1 << IDX_BITS;

   logic                valid_q  [ENTRIES];
   logic [TAG_BITS-1:0] tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   ctr_e                ctr_q    [ENTRIES];

   // Only valid bits and counters carry reset; tag/target are qualified by valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CTR_RESET;
         end
      end else if (we_i) begin
         valid_q[upd_idx_i] <= wr_valid_i;
         ctr_q[upd_idx_i]   <= wr_ctr_i;
      end
   end

   always_ff @(posedge clk) begin
      if (we_i && !reset) begin
         tag_q[upd_idx_i]    <= wr_tag_i;
         target_q[upd_idx_i] <= wr_target_i;
      end
   end

   assign rd_valid_o   = valid_q[rd_idx_i];
   assign rd_tag_o     = tag_q[rd_idx_i];
   assign rd_target_o  = target_q[rd_idx_i];
   assign rd_ctr_o     = ctr_q[rd_idx_i];

   assign upd_valid_o  = valid_q[upd_idx_i];
   assign upd_tag_o    = tag_q[upd_idx_i];
   assign upd_target_o = target_q[upd_idx_i];
   assign upd_ctr_o    = ctr_q[upd_idx_i];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: BTB lookup for IF_PC, training from the ID-stage
// resolution, mispredict/redirect generation and saturating statistics.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int IDX_BITS = 6,
   parameter int TAG_BITS = 30 - IDX_BITS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IF_PC,
   output logic        Predict_Taken,
   output logic [31:0] Predict_Target,
   input  logic        Res_Valid,
   input  logic [31:0] Res_PC,
   input  logic        Res_Taken,
   input  logic [31:0] Res_Target,
   input  logic        Res_PredTaken,
   input  logic [31:0] Res_PredTarget,
   output logic        Mispredict,
   output logic [31:0] Redirect_PC,
   output logic [31:0] Branch_Cnt,
   output logic [31:0] Mispredict_Cnt
);

   logic [IDX_BITS-1:0] if_idx, res_idx;
   logic [TAG_BITS-1:0] if_tag, res_tag;
   logic                rd_valid, upd_valid;
   logic [TAG_BITS-1:0] rd_tag, upd_tag;
   logic [31:0]         rd_target, upd_target;
   ctr_e                rd_ctr, upd_ctr;
   logic                if_hit, res_hit;
   logic                we;
   logic [31:0]         wr_target;
   ctr_e                wr_ctr;
   logic [31:0]         branch_cnt_q, branch_cnt_d;
   logic [31:0]         mispred_cnt_q, mispred_cnt_d;
   logic                unused_pc_lsbs;

   // Instructions are word aligned, so PC[1:0] never participates.
   assign unused_pc_lsbs = ^{IF_PC[1:0], Res_PC[1:0]};

   assign if_idx  = IF_PC[IDX_BITS+1:2];
   assign if_tag  = IF_PC[31:IDX_BITS+2];
   assign res_idx = Res_PC[IDX_BITS+1:2];
   assign res_tag = Res_PC[31:IDX_BITS+2];

   btb_table #(
      .IDX_BITS(IDX_BITS),
      .TAG_BITS(TAG_BITS)
   ) u_btb (
      .clk          (clk),
      .reset        (reset),
      .rd_idx_i     (if_idx),
      .rd_valid_o   (rd_valid),
      .rd_tag_o     (rd_tag),
      .rd_target_o  (rd_target),
      .rd_ctr_o     (rd_ctr),
      .upd_idx_i    (res_idx),
      .upd_valid_o  (upd_valid),
      .upd_tag_o    (upd_tag),
      .upd_target_o (upd_target),
      .upd_ctr_o    (upd_ctr),
      .we_i         (we),
      .wr_valid_i   (1'b1),
      .wr_tag_i     (res_tag),
      .wr_target_i  (wr_target),
      .wr_ctr_i     (wr_ctr)
   );

   // Lookup reads pre-update contents; there is deliberately no write bypass.
   assign if_hit         = rd_valid && (rd_tag == if_tag);
   assign Predict_Taken  = if_hit && rd_ctr[1];
   assign Predict_Target = if_hit ? rd_target : 32'd0;

   assign res_hit = upd_valid && (upd_tag == res_tag);

   always_comb begin
      we            = 1'b0;
      wr_target     = upd_target;
      wr_ctr        = upd_ctr;
      Mispredict    = 1'b0;
      Redirect_PC   = Res_Taken ? Res_Target : Res_PC + 32'd4;
      branch_cnt_d  = branch_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (Res_Valid) begin
         Mispredict   = (Res_Taken != Res_PredTaken) ||
                        (Res_Taken && (Res_PredTarget != Res_Target));
         branch_cnt_d = sat_inc32(branch_cnt_q);
         if (Mispredict) begin
            mispred_cnt_d = sat_inc32(mispred_cnt_q);
         end
         if (res_hit) begin
            we     = 1'b1;
            wr_ctr = sat2_next(upd_ctr, Res_Taken);
            if (Res_Taken) begin
               wr_target = Res_Target;
            end
         end else if (Res_Taken) begin
            // Miss-and-taken allocates, evicting any aliasing occupant.
            we        = 1'b1;
            wr_target = Res_Target;
            wr_ctr    = CTR_ALLOC;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         branch_cnt_q  <= 32'd0;
         mispred_cnt_q <= 32'd0;
      end else begin
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign Branch_Cnt     = branch_cnt_q;
   assign Mispredict_Cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus a short
// randomized phase checked against a small behavioural model.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IF_PC;
   logic        Predict_Taken;
   logic [31:0] Predict_Target;
   logic        Res_Valid;
   logic [31:0] Res_PC;
   logic        Res_Taken;
   logic [31:0] Res_Target;
   logic        Res_PredTaken;
   logic [31:0] Res_PredTarget;
   logic        Mispredict;
   logic [31:0] Redirect_PC;
   logic [31:0] Branch_Cnt;
   logic [31:0] Mispredict_Cnt;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk            (clk),
      .reset          (reset),
      .IF_PC          (IF_PC),
      .Predict_Taken  (Predict_Taken),
      .Predict_Target (Predict_Target),
      .Res_Valid      (Res_Valid),
      .Res_PC         (Res_PC),
      .Res_Taken      (Res_Taken),
      .Res_Target     (Res_Target),
      .Res_PredTaken  (Res_PredTaken),
      .Res_PredTarget (Res_PredTarget),
      .Mispredict     (Mispredict),
      .Redirect_PC    (Redirect_PC),
      .Branch_Cnt     (Branch_Cnt),
      .Mispredict_Cnt (Mispredict_Cnt)
   );

   localparam int O_PT = 0, O_PTGT = 1, O_MIS = 2, O_RED = 3, O_BC = 4, O_MC = 5;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fails  = 0;

   // behavioural model used in the randomized phase
   logic        m_valid [64];
   logic [23:0] m_tag   [64];
   logic [31:0] m_tgt   [64];
   logic [1:0]  m_ctr   [64];
   logic [31:0] m_bc, m_mc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         O_PT:    return {31'd0, Predict_Taken};
         O_PTGT:  return Predict_Target;
         O_MIS:   return {31'd0, Mispredict};
         O_RED:   return Redirect_PC;
         O_BC:    return Branch_Cnt;
         default: return Mispredict_Cnt;
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic settle();
      exp_t e;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drv(input logic [31:0] ifpc, input logic rv, input logic [31:0] rpc,
                      input logic rt, input logic [31:0] rtgt,
                      input logic rpt, input logic [31:0] rptgt);
      IF_PC          = ifpc;
      Res_Valid      = rv;
      Res_PC         = rpc;
      Res_Taken      = rt;
      Res_Target     = rtgt;
      Res_PredTaken  = rpt;
      Res_PredTarget = rptgt;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 2'b01;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
      end
      m_bc = 0;
      m_mc = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   localparam logic [31:0] PC_A = 32'h0040_0010;
   localparam logic [31:0] PC_B = 32'h0040_0110;
   localparam logic [31:0] T_A  = 32'h0040_0040;

   initial begin
      reset = 1'b1;
      drv(32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      tick();
      tick();
      reset = 1'b0;

      // reset state
      drv(PC_A, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      push("rst_pt", O_PT, 0);
      push("rst_ptgt", O_PTGT, 0);
      push("rst_mis", O_MIS, 0);
      push("rst_bc", O_BC, 0);
      push("rst_mc", O_MC, 0);
      settle();

      // allocate on taken miss; same-cycle lookup sees the empty entry
      drv(PC_A, 1'b1, PC_A, 1'b1, T_A, 1'b0, 32'd0);
      push("alloc_mis", O_MIS, 1);
      push("alloc_red", O_RED, T_A);
      push("samecyc_pt", O_PT, 0);
      settle();
      tick();
      drv(PC_A, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      push("alloc_pt", O_PT, 1);
      push("alloc_ptgt", O_PTGT, T_A);
      push("alloc_bc", O_BC, 1);
      push("alloc_mc", O_MC, 1);
      settle();

      // not-taken twice: WT->WNT->SNT
      drv(PC_A, 1'b1, PC_A, 1'b0, 32'd0, 1'b1, T_A);
      push("nt1_mis", O_MIS, 1);
      push("nt1_red", O_RED, 32'h0040_0014);
      settle();
      tick();
      drv(PC_A, 1'b1, PC_A, 1'b0, 32'd0, 1'b0, 32'd0);
      push("nt2_mis", O_MIS, 0);
      push("wnt_pt", O_PT, 0);
      push("wnt_ptgt", O_PTGT, T_A);
      settle();
      tick();
      drv(PC_A, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      push("snt_pt", O_PT, 0);
      push("nt_bc", O_BC, 3);
      push("nt_mc", O_MC, 2);
      settle();

      // taken x4 from SNT, saturating at ST; a not-taken then leaves WT (still taken)
      drv(PC_A, 1'b1, PC_A, 1'b1, T_A, 1'b0, 32'd0);
      push("t1_mis", O_MIS, 1);
      settle();
      tick();
      drv(PC_A, 1'b1, PC_A, 1'b1, T_A, 1'b0, 32'd0);
      push("t2_pre_pt", O_PT, 0);
      settle();
      tick();
      drv(PC_A, 1'b1, PC_A, 1'b1, T_A, 1'b1, T_A);
      push("t3_pre_pt", O_PT, 1);
      push("t3_mis", O_MIS, 0);
      settle();
      tick();
      drv(PC_A, 1'b1, PC_A, 1'b1, T_A, 1'b1, T_A);
      push("t4_mis", O_MIS, 0);
      settle();
      tick();
      drv(PC_A, 1'b1, PC_A, 1'b0, 32'd0, 1'b1, T_A);
      push("st_nt_mis", O_MIS, 1);
      push("st_nt_red", O_RED, 32'h0040_0014);
      settle();
      tick();
      drv(PC_A, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      push("st_sat_pt", O_PT, 1);
      push("seq_bc", O_BC, 8);
      push("seq_mc", O_MC, 5);
      settle();

      // alias: same index 4, different tag, evicts occupant
      drv(PC_A, 1'b1, PC_B, 1'b1, 32'h0040_0200, 1'b0, 32'd0);
      push("alias_mis", O_MIS, 1);
      settle();
      tick();
      drv(PC_A, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      push("alias_old_pt", O_PT, 0);
      push("alias_old_ptgt", O_PTGT, 0);
      settle();
      IF_PC = PC_B;
      push("alias_new_pt", O_PT, 1);
      push("alias_new_ptgt", O_PTGT, 32'h0040_0200);
      settle();

      // correct direction, wrong target
      drv(PC_B, 1'b1, PC_B, 1'b1, 32'h200, 1'b1, 32'h100);
      push("wtgt_mis", O_MIS, 1);
      push("wtgt_red", O_RED, 32'h200);
      settle();
      tick();
      drv(PC_B, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      push("wtgt_pt", O_PT, 1);
      push("wtgt_ptgt", O_PTGT, 32'h200);
      settle();

      // fall-through wraps modulo 2^32
      drv(PC_B, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0, 1'b0, 32'd0);
      push("wrap_red", O_RED, 32'd0);
      push("wrap_mis", O_MIS, 0);
      settle();
      tick();

      // reset with a concurrent taken update: update discarded
      reset = 1'b1;
      drv(32'h0040_0300, 1'b1, 32'h0040_0300, 1'b1, 32'h1234, 1'b0, 32'd0);
      tick();
      reset = 1'b0;
      drv(32'h0040_0300, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      push("rst2_pt", O_PT, 0);
      push("rst2_ptgt", O_PTGT, 0);
      push("rst2_bc", O_BC, 0);
      push("rst2_mc", O_MC, 0);
      settle();
      IF_PC = PC_B;
      push("rst2_clr_pt", O_PT, 0);
      settle();

      // randomized phase against the model
      model_reset();
      for (int n = 0; n < 300; n++) begin
         logic [31:0] ifpc, rpc, rtgt, rptgt, e_red;
         logic        rv, rt, rpt, e_mis, hit_if, hit_r;
         int          ii, ri;
         ifpc  = 32'h0040_0000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 1)) * 32'h100;
         rpc   = 32'h0040_0000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 1)) * 32'h100;
         rv    = ($urandom_range(0, 3) != 0);
         rt    = $urandom_range(0, 1) == 1;
         rtgt  = 32'h0041_0000 + 32'($urandom_range(0, 3)) * 32'h40;
         rpt   = $urandom_range(0, 1) == 1;
         rptgt = ($urandom_range(0, 1) == 1) ? rtgt : 32'h0041_0000 + 32'($urandom_range(0, 3)) * 32'h40;
         drv(ifpc, rv, rpc, rt, rtgt, rpt, rptgt);
         ii     = int'(ifpc[7:2]);
         ri     = int'(rpc[7:2]);
         hit_if = m_valid[ii] && (m_tag[ii] == ifpc[31:8]);
         e_mis  = rv && ((rt != rpt) || (rt && (rptgt != rtgt)));
         e_red  = rt ? rtgt : rpc + 32'd4;
         push("rnd_pt", O_PT, {31'd0, hit_if && m_ctr[ii][1]});
         push("rnd_ptgt", O_PTGT, hit_if ? m_tgt[ii] : 32'd0);
         push("rnd_mis", O_MIS, {31'd0, e_mis});
         push("rnd_red", O_RED, e_red);
         push("rnd_bc", O_BC, m_bc);
         push("rnd_mc", O_MC, m_mc);
         settle();
         if (rv) begin
            hit_r = m_valid[ri] && (m_tag[ri] == rpc[31:8]);
            m_bc  = m_bc + 1;
            if (e_mis) m_mc = m_mc + 1;
            if (hit_r) begin
               if (rt) begin
                  m_tgt[ri] = rtgt;
                  if (m_ctr[ri] != 2'b11) m_ctr[ri] = m_ctr[ri] + 2'b01;
               end else if (m_ctr[ri] != 2'b00) begin
                  m_ctr[ri] = m_ctr[ri] - 2'b01;
               end
            end else if (rt) begin
               m_valid[ri] = 1'b1;
               m_tag[ri]   = rpc[31:8];
               m_tgt[ri]   = rtgt;
               m_ctr[ri]   = 2'b10;
            end
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
